// File: rtl/feeder_dispense_ctrl.sv
// Pet-feeder dispense controller: runs the auger for one portion per request
// edge, confirms the drop on a debounced sensor, retries once on a miss and
// latches a fault on a jam, while tracking the portions left in the hopper.
module feeder_dispense_ctrl #(
  parameter logic [31:0] CLOCK_FREQ      = 32'd50_000_000,
  parameter logic [31:0] RUN_CYCLES      = 32'd25_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd100_000_000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [1:0]  MAX_RETRY       = 2'd1,
  parameter logic [2:0]  MAX_PORCIONES   = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_m_on,
  input  logic       i_sensor,
  input  logic       i_refill,
  output logic       o_motor,
  output logic       o_m_state,
  output logic [2:0] o_porciones,
  output logic       o_empty,
  output logic       o_fault,
  output logic       o_busy
);

  if (CLOCK_FREQ == 32'd0 || RUN_CYCLES == 32'd0 || TIMEOUT_CYCLES == 32'd0 ||
      DEBOUNCE_CYCLES == 16'd0 || MAX_PORCIONES == 3'd0) begin : g_param_check
    $error("feeder_dispense_ctrl: cycle parameters and MAX_PORCIONES must be nonzero");
  end

  localparam logic [31:0] RUN_LAST = RUN_CYCLES - 32'd1;
  localparam logic [31:0] TO_LAST  = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] DB_LAST  = {16'd0, DEBOUNCE_CYCLES} - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state_q;
  logic        m_on_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        deb_q;
  logic        deb_prev_q;
  logic [31:0] db_cnt_q;
  logic [31:0] run_cnt_q;
  logic [31:0] wait_cnt_q;
  logic [1:0]  retry_q;
  logic [2:0]  porc_q;
  logic        motor_q;
  logic        ack_q;
  logic        fault_q;
  logic        busy_q;

  logic trig;
  logic drop;

  assign trig = i_m_on & ~m_on_q;
  assign drop = deb_q & ~deb_prev_q;

  // Sensor synchronizer and debouncer; the debounced value only follows the
  // synchronized input after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= i_sensor;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q == deb_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        deb_q    <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 32'd1;
      end
    end
  end

  // Dispense FSM with registered Moore outputs (one cycle behind the state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      m_on_q     <= 1'b0;
      run_cnt_q  <= '0;
      wait_cnt_q <= '0;
      retry_q    <= '0;
      porc_q     <= MAX_PORCIONES;
      motor_q    <= 1'b0;
      ack_q      <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      m_on_q  <= i_m_on;
      motor_q <= (state_q == S_RUN);
      ack_q   <= (state_q == S_DONE);
      busy_q  <= (state_q != S_IDLE);
      // Fault output drops on the refill edge itself, together with the
      // portion reload, instead of lagging the state by a cycle.
      fault_q <= (state_q == S_FAULT) && !i_refill;

      case (state_q)
        S_IDLE: begin
          if (trig && porc_q != 3'd0) begin
            state_q   <= S_RUN;
            run_cnt_q <= '0;
            retry_q   <= '0;
          end
          if (i_refill) begin
            porc_q <= MAX_PORCIONES;
          end
        end
        S_RUN: begin
          if (run_cnt_q == RUN_LAST) begin
            state_q    <= S_CHECK;
            run_cnt_q  <= '0;
            wait_cnt_q <= '0;
          end else begin
            run_cnt_q <= run_cnt_q + 32'd1;
          end
        end
        S_CHECK: begin
          if (drop) begin
            state_q <= S_DONE;
          end else if (wait_cnt_q == TO_LAST) begin
            wait_cnt_q <= '0;
            if (retry_q < MAX_RETRY) begin
              state_q   <= S_RUN;
              run_cnt_q <= '0;
              retry_q   <= retry_q + 2'd1;
            end else begin
              state_q <= S_FAULT;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end
        S_DONE: begin
          porc_q  <= (porc_q == 3'd0) ? 3'd0 : porc_q - 3'd1;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          if (i_refill) begin
            porc_q  <= MAX_PORCIONES;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_motor     = motor_q;
  assign o_m_state   = ack_q;
  assign o_porciones = porc_q;
  assign o_empty     = (porc_q == 3'd0);
  assign o_fault     = fault_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_feeder_dispense_ctrl.sv
// Bench for feeder_dispense_ctrl: cycle vector table, hand-written corner
// sequences and randomized transactions against a portion/fault model.
module tb_feeder_dispense_ctrl;

  localparam int RUN_C = 8;
  localparam int TO_C  = 20;
  localparam int MAXP  = 3;

  localparam int SEL_MOTOR = 0;
  localparam int SEL_BUSY  = 1;
  localparam int SEL_FAULT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_m_on;
  logic       i_sensor;
  logic       i_refill;
  logic       o_motor;
  logic       o_m_state;
  logic [2:0] o_porciones;
  logic       o_empty;
  logic       o_fault;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int motor_cnt = 0;
  int ack_cnt = 0;
  int run_len = 0;
  int n_runs = 0;
  bit chk_runs = 1'b0;

  feeder_dispense_ctrl #(
    .CLOCK_FREQ     (32'd50_000_000),
    .RUN_CYCLES     (32'd8),
    .TIMEOUT_CYCLES (32'd20),
    .DEBOUNCE_CYCLES(16'd3),
    .MAX_RETRY      (2'd1),
    .MAX_PORCIONES  (3'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_m_on     (i_m_on),
    .i_sensor   (i_sensor),
    .i_refill   (i_refill),
    .o_motor    (o_motor),
    .o_m_state  (o_m_state),
    .o_porciones(o_porciones),
    .o_empty    (o_empty),
    .o_fault    (o_fault),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    bit rst, m_on, sens, refill;
    bit motor, ack, busy, fault, empty;
    int porc;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Everything happens on the falling edge: outputs are observed, then inputs change.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_motor === 1'b1) begin
      motor_cnt++;
      run_len++;
    end else if (run_len != 0) begin
      n_runs++;
      if (chk_runs) check("motor_run_len", run_len, RUN_C);
      run_len = 0;
    end
    if (o_m_state === 1'b1) ack_cnt++;
  endtask

  function automatic int sig(input int sel);
    case (sel)
      SEL_MOTOR: return int'(o_motor);
      SEL_BUSY:  return int'(o_busy);
      SEL_FAULT: return int'(o_fault);
      default:   return int'(o_m_state);
    endcase
  endfunction

  task automatic wait_for(input int sel, input int lvl, input int maxc, input string nm);
    int n;
    n = 0;
    while (sig(sel) != lvl && n < maxc) begin
      tick();
      n++;
    end
    check(nm, sig(sel), lvl);
  endtask

  task automatic trig_pulse();
    i_m_on = 1'b1;
    tick();
    i_m_on = 1'b0;
  endtask

  task automatic sensor_pulse(input int len);
    i_sensor = 1'b1;
    repeat (len) tick();
    i_sensor = 1'b0;
  endtask

  task automatic refill_pulse();
    i_refill = 1'b1;
    tick();
    i_refill = 1'b0;
  endtask

  task automatic dispense_ok(input int slen);
    trig_pulse();
    wait_for(SEL_MOTOR, 1, 4, "ok_run_start");
    wait_for(SEL_MOTOR, 0, 12, "ok_run_end");
    sensor_pulse(slen);
    wait_for(SEL_BUSY, 0, 40, "ok_done");
  endtask

  int c0, m0, a0, r0;
  int m_porc, m_runs, m_acks;
  bit m_fault;
  int act, oc;
  bit served;

  initial begin
    rst = 1'b1; i_m_on = 1'b0; i_sensor = 1'b0; i_refill = 1'b0;

    //        n  rst m_on sens rfl  mot ack busy flt emp porc
    tbl[0]  = '{2, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3};
    tbl[1]  = '{1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3};
    tbl[2]  = '{8, 0, 1, 0, 0,  1, 0, 1, 0, 0, 3};
    tbl[3]  = '{6, 0, 1, 1, 0,  0, 0, 1, 0, 0, 3};
    tbl[4]  = '{1, 0, 1, 1, 0,  0, 1, 1, 0, 0, 2};
    tbl[5]  = '{3, 0, 1, 1, 0,  0, 0, 0, 0, 0, 2};
    tbl[6]  = '{8, 0, 1, 0, 0,  0, 0, 0, 0, 0, 2};
    tbl[7]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2};
    tbl[8]  = '{1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 2};
    tbl[9]  = '{4, 0, 1, 0, 0,  1, 0, 1, 0, 0, 2};
    tbl[10] = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 3};
    tbl[11] = '{1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3};
    tbl[12] = '{8, 0, 1, 0, 0,  1, 0, 1, 0, 0, 3};
    tbl[13] = '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3};

    // Reset, held-request single dispense, normal drop, reset mid-run.
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst      = tbl[i].rst;
        i_m_on   = tbl[i].m_on;
        i_sensor = tbl[i].sens;
        i_refill = tbl[i].refill;
        tick();
        check($sformatf("vec%0d.%0d_motor", i, k), int'(o_motor), int'(tbl[i].motor));
        check($sformatf("vec%0d.%0d_ack", i, k), int'(o_m_state), int'(tbl[i].ack));
        check($sformatf("vec%0d.%0d_busy", i, k), int'(o_busy), int'(tbl[i].busy));
        check($sformatf("vec%0d.%0d_fault", i, k), int'(o_fault), int'(tbl[i].fault));
        check($sformatf("vec%0d.%0d_empty", i, k), int'(o_empty), int'(tbl[i].empty));
        check($sformatf("vec%0d.%0d_porc", i, k), int'(o_porciones), tbl[i].porc);
      end
    end

    rst = 1'b0; i_m_on = 1'b0; i_sensor = 1'b0; i_refill = 1'b0;
    tick();
    run_len = 0;
    chk_runs = 1'b1;

    // Retry: first attempt misses, second attempt's drop gives one ack.
    a0 = ack_cnt; r0 = n_runs;
    trig_pulse();
    wait_for(SEL_MOTOR, 1, 4, "retry_run1_start");
    wait_for(SEL_MOTOR, 0, 12, "retry_run1_end");
    c0 = cyc;
    wait_for(SEL_MOTOR, 1, 30, "retry_run2_start");
    check("retry_gap", cyc - c0, TO_C);
    wait_for(SEL_MOTOR, 0, 12, "retry_run2_end");
    sensor_pulse(6);
    wait_for(SEL_BUSY, 0, 40, "retry_done");
    check("retry_acks", ack_cnt - a0, 1);
    check("retry_runs", n_runs - r0, 2);
    check("retry_porc", int'(o_porciones), 2);

    // Jam: both attempts miss, fault latches and blocks requests until refill.
    a0 = ack_cnt; r0 = n_runs; m0 = motor_cnt;
    trig_pulse();
    wait_for(SEL_FAULT, 1, 80, "jam_fault");
    check("jam_runs", n_runs - r0, 2);
    check("jam_motor_cycles", motor_cnt - m0, 2 * RUN_C);
    check("jam_acks", ack_cnt - a0, 0);
    check("jam_motor_off", int'(o_motor), 0);
    trig_pulse();
    repeat (15) tick();
    check("jam_trig_ignored", motor_cnt - m0, 2 * RUN_C);
    check("jam_fault_held", int'(o_fault), 1);
    refill_pulse();
    check("jam_refill_fault", int'(o_fault), 0);
    check("jam_refill_porc", int'(o_porciones), MAXP);
    tick();
    check("jam_refill_idle", int'(o_busy), 0);

    // Empty: three dispenses drain the hopper, a fourth request is dropped.
    for (int j = 0; j < 3; j++) dispense_ok(4);
    check("empty_porc", int'(o_porciones), 0);
    check("empty_flag", int'(o_empty), 1);
    m0 = motor_cnt; a0 = ack_cnt;
    trig_pulse();
    repeat (15) tick();
    check("empty_no_motor", motor_cnt - m0, 0);
    check("empty_no_ack", ack_cnt - a0, 0);
    refill_pulse();
    check("empty_refill_porc", int'(o_porciones), MAXP);
    check("empty_refill_flag", int'(o_empty), 0);

    // Glitch of two samples is rejected; a three-sample pulse is accepted.
    a0 = ack_cnt;
    trig_pulse();
    wait_for(SEL_MOTOR, 1, 4, "glitch_run_start");
    wait_for(SEL_MOTOR, 0, 12, "glitch_run_end");
    sensor_pulse(2);
    wait_for(SEL_MOTOR, 1, 30, "glitch_retry_start");
    check("glitch_no_ack", ack_cnt - a0, 0);
    wait_for(SEL_MOTOR, 0, 12, "glitch_retry_end");
    sensor_pulse(3);
    wait_for(SEL_BUSY, 0, 40, "glitch_done");
    check("glitch_ack", ack_cnt - a0, 1);
    check("glitch_porc", int'(o_porciones), MAXP - 1);

    // Randomized transactions against a portion/fault bookkeeping model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_len = 0; n_runs = 0; ack_cnt = 0;
    m_porc = MAXP; m_fault = 1'b0; m_runs = 0; m_acks = 0;
    for (int t = 0; t < 25; t++) begin
      act = $urandom_range(0, 3);
      if (act == 0) begin
        refill_pulse();
        m_porc = MAXP;
        m_fault = 1'b0;
      end else begin
        oc = $urandom_range(0, 2);
        served = !m_fault && (m_porc > 0);
        repeat ($urandom_range(0, 3)) tick();
        trig_pulse();
        if (served) begin
          wait_for(SEL_MOTOR, 1, 4, "rnd_run1_start");
          if ($urandom_range(0, 1) == 1) begin
            i_m_on = 1'b1;
            i_refill = 1'($urandom_range(0, 1));
            tick();
            i_m_on = 1'b0;
            i_refill = 1'b0;
          end
          wait_for(SEL_MOTOR, 0, 12, "rnd_run1_end");
          if (oc != 0) begin
            wait_for(SEL_MOTOR, 1, 30, "rnd_run2_start");
            wait_for(SEL_MOTOR, 0, 12, "rnd_run2_end");
          end
          if (oc != 2) begin
            repeat ($urandom_range(0, 8)) tick();
            sensor_pulse($urandom_range(3, 7));
            wait_for(SEL_BUSY, 0, 40, "rnd_done");
            m_acks++;
            m_porc--;
          end else begin
            wait_for(SEL_FAULT, 1, 30, "rnd_fault");
            m_fault = 1'b1;
          end
          m_runs += (oc == 0) ? 1 : 2;
        end else begin
          repeat (12) tick();
        end
      end
      repeat (6) tick();
      check($sformatf("rnd%0d_porc", t), int'(o_porciones), m_porc);
      check($sformatf("rnd%0d_fault", t), int'(o_fault), int'(m_fault));
      check($sformatf("rnd%0d_empty", t), int'(o_empty), int'(m_porc == 0));
      check($sformatf("rnd%0d_runs", t), n_runs, m_runs);
      check($sformatf("rnd%0d_acks", t), ack_cnt, m_acks);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
